// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/owner encodings and defaults for the memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;
  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } arb_owner_e;
  localparam int LINE_WORDS_DEF = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-way round-robin picker; a tie goes to whoever was not granted last.
module mem_arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  arb_owner_e i_last,
  output logic       o_valid,
  output arb_owner_e o_grant
);
  assign o_valid = |i_req;
  assign o_grant = (&i_req) ? ((i_last == ARB_IC) ? ARB_DC : ARB_IC)
                            : (i_req[1] ? ARB_DC : ARB_IC);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between icache fills and dcache fills/write-backs,
// running each grant as a full line burst.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic                          ic_rvalid,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_W-1:0]             dc_addr,
  input  logic [DATA_W-1:0]             dc_wdata,
  output logic                          dc_rvalid,
  output logic                          dc_done,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx,
  output logic [$clog2(LINE_WORDS)-1:0] rword,
  output logic [DATA_W-1:0]             rdata,
  output logic                          busy,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int LSB = OFF + 2;
  arb_state_e        r_state, w_next;
  arb_owner_e        r_owner, r_last, w_grant;
  logic              r_we, r_ic_rvalid, r_dc_rvalid;
  logic              w_valid, w_ack, w_last_ack, w_start;
  logic [OFF-1:0]    r_cnt, r_rword;
  logic [ADDR_W-1:0] r_base, w_addr;
  logic [DATA_W-1:0] r_rdata;
  mem_arb_rr2 u_rr (
    .i_req   ({dc_req, ic_req}),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_grant (w_grant)
  );
  assign w_addr     = (w_grant == ARB_DC) ? dc_addr : ic_addr;
  assign w_start    = (r_state == ARB_IDLE) && w_valid;
  assign w_ack      = (r_state == ARB_BUSY) && mem_ack;
  assign w_last_ack = w_ack && (r_cnt == OFF'(LINE_WORDS - 1));
  always_comb begin
    w_next = (r_state == ARB_IDLE) ? (w_valid ? ARB_BUSY : ARB_IDLE)
           : (r_state == ARB_DONE) ? ARB_IDLE
           : (w_last_ack ? ARB_DONE : ARB_BUSY);
  end
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ARB_IDLE;
    else        r_state <= w_next;
  end
  // Grant-time latches; nothing about the requester is resampled until IDLE again.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_owner     <= ARB_IC;
      r_last      <= ARB_IC;
      r_we        <= 1'b0;
      r_base      <= '0;
      r_cnt       <= '0;
      r_rword     <= '0;
      r_rdata     <= '0;
      r_ic_rvalid <= 1'b0;
      r_dc_rvalid <= 1'b0;
    end else begin
      r_ic_rvalid <= w_ack && !r_we && (r_owner == ARB_IC);
      r_dc_rvalid <= w_ack && !r_we && (r_owner == ARB_DC);
      if (w_start) begin
        r_owner <= w_grant;
        r_last  <= w_grant;
        r_we    <= (w_grant == ARB_DC) && dc_we;
        r_base  <= w_addr & ~ADDR_W'((1 << LSB) - 1);
        r_cnt   <= '0;
      end
      if (w_ack) begin
        r_rdata <= mem_rdata;
        r_rword <= r_cnt;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end
  assign busy      = r_state != ARB_IDLE;
  assign mem_req   = r_state == ARB_BUSY;
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = mem_req ? (r_base | (ADDR_W'(r_cnt) << 2)) : '0;
  assign mem_wdata = mem_we ? dc_wdata : '0;
  assign word_idx  = r_cnt;
  assign rword     = r_rword;
  assign rdata     = r_rdata;
  assign ic_rvalid = r_ic_rvalid;
  assign dc_rvalid = r_dc_rvalid;
  assign ic_done   = (r_state == ARB_DONE) && (r_owner == ARB_IC);
  assign dc_done   = (r_state == ARB_DONE) && (r_owner == ARB_DC);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for the icache/dcache memory arbiter.
module tb_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        ic_req, dc_req, dc_we, mem_ack;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic        ic_rvalid, ic_done, dc_rvalid, dc_done, busy, mem_req, mem_we;
  logic [1:0]  word_idx, rword;
  logic [31:0] rdata, mem_addr, mem_wdata;
  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_done(dc_done), .word_idx(word_idx), .rword(rword),
    .rdata(rdata), .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
    ic_addr = 0; dc_addr = 0; dc_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  task automatic wait_done(input logic want_dc, output logic ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      ok = want_dc ? dc_done : ic_done;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    @(negedge clock);
    tests++;
    if ({busy, mem_req, mem_we, ic_rvalid, ic_done, dc_rvalid, dc_done} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, mem_req, mem_we, ic_rvalid, ic_done, dc_rvalid, dc_done});
    end
    tests++;
    if (mem_addr !== 0 || mem_wdata !== 0 || rdata !== 0 || rword !== 0 || word_idx !== 0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h rword=%0d widx=%0d expected all 0",
               mem_addr, mem_wdata, rdata, rword, word_idx);
    end
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_ic_fill();
    int k = 0, j = 0, occ = 1, dones = 0;
    @(negedge clock);
    ic_req = 1; ic_addr = 32'h1238; mem_ack = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (busy) occ++;
      if (ic_rvalid) begin
        tests++;
        if (rword !== 2'(j) || rdata !== 32'hA0 + j) begin
          fails++;
          $display("FAIL ic_fill_rdata: rword=%0d rdata=%h expected rword=%0d rdata=%h",
                   rword, rdata, j, 32'hA0 + j);
        end
        j++;
      end
      if (ic_done) begin
        dones++;
        tests++;
        if (!ic_rvalid || j !== 4) begin
          fails++;
          $display("FAIL ic_fill_done: rvalid=%b words=%0d expected rvalid=1 words=4", ic_rvalid, j);
        end
        ic_req = 0;
      end
      if (mem_req) begin
        tests++;
        if (mem_addr !== 32'h1230 + 4 * k || mem_we !== 1'b0) begin
          fails++;
          $display("FAIL ic_fill_addr: addr=%h we=%b expected addr=%h we=0",
                   mem_addr, mem_we, 32'h1230 + 4 * k);
        end
        mem_rdata = 32'hA0 + k;
        k++;
      end
    end
    mem_ack = 0;
    tests++;
    if (occ !== 6 || dones !== 1 || k !== 4) begin
      fails++;
      $display("FAIL ic_fill_occupancy: occ=%0d dones=%0d words=%0d expected 6/1/4", occ, dones, k);
    end
  endtask

  task automatic test_tie();
    logic ok;
    do_reset();
    @(negedge clock);
    ic_req = 1; dc_req = 1; ic_addr = 32'h100; dc_addr = 32'h200; mem_ack = 1;
    @(negedge clock);
    tests++;
    if (!mem_req || mem_addr !== 32'h200) begin
      fails++;
      $display("FAIL tie_first: req=%b addr=%h expected req=1 addr=00000200", mem_req, mem_addr);
    end
    wait_done(1'b1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL tie_dc_done: got timeout expected dc_done"); end
    dc_req = 0;
    repeat (2) @(negedge clock);
    tests++;
    if (!mem_req || mem_addr !== 32'h100) begin
      fails++;
      $display("FAIL tie_second: req=%b addr=%h expected req=1 addr=00000100", mem_req, mem_addr);
    end
    wait_done(1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL tie_ic_done: got timeout expected ic_done"); end
    dc_req = 1;
    @(negedge clock);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL tie_done_ignores_req: busy=%b expected 0", busy);
    end
    @(negedge clock);
    tests++;
    if (!mem_req || mem_addr !== 32'h200) begin
      fails++;
      $display("FAIL tie_again: req=%b addr=%h expected req=1 addr=00000200", mem_req, mem_addr);
    end
    wait_done(1'b1, ok);
    ic_req = 0; dc_req = 0; mem_ack = 0;
    @(negedge clock);
  endtask

  task automatic test_writeback();
    int k = 0, ph = 0, rv = 0, dn = 0;
    @(negedge clock);
    dc_req = 1; dc_we = 1; dc_addr = 32'h2000; mem_ack = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (dc_rvalid) rv++;
      if (dc_done) begin dn++; dc_req = 0; dc_we = 0; end
      mem_ack = 0;
      if (mem_req) begin
        dc_wdata = 32'hD0 + k;
        #1;
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h2000 + 4 * k || word_idx !== 2'(k) ||
            mem_wdata !== 32'hD0 + k) begin
          fails++;
          $display("FAIL wb_word: we=%b addr=%h widx=%0d wdata=%h expected 1/%h/%0d/%h",
                   mem_we, mem_addr, word_idx, mem_wdata, 32'h2000 + 4 * k, k, 32'hD0 + k);
        end
        ph++;
        if (ph == 3) begin mem_ack = 1; ph = 0; k++; end
      end
    end
    mem_ack = 0;
    tests++;
    if (k !== 4 || rv !== 0 || dn !== 1) begin
      fails++;
      $display("FAIL wb_summary: words=%0d rvalids=%0d dones=%0d expected 4/0/1", k, rv, dn);
    end
    tests++;
    if (mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL wb_idle_wdata: wdata=%h we=%b expected 0/0", mem_wdata, mem_we);
    end
  endtask

  task automatic test_midreset();
    logic bad = 0;
    @(negedge clock);
    ic_req = 1; ic_addr = 32'h4000; mem_ack = 1; mem_rdata = 32'h11;
    repeat (3) @(negedge clock);
    tests++;
    if (!ic_rvalid || rword !== 2'd1 || !mem_req) begin
      fails++;
      $display("FAIL midreset_pre: rvalid=%b rword=%0d req=%b expected 1/1/1", ic_rvalid, rword, mem_req);
    end
    reset = 0; ic_req = 0;
    @(negedge clock);
    tests++;
    if ({mem_req, busy, ic_rvalid, ic_done} !== 4'b0 || mem_addr !== 0 || rdata !== 0 ||
        rword !== 0 || word_idx !== 0) begin
      fails++;
      $display("FAIL midreset_clear: req=%b busy=%b rv=%b done=%b addr=%h rdata=%h expected all 0",
               mem_req, busy, ic_rvalid, ic_done, mem_addr, rdata);
    end
    reset = 1;
    repeat (3) begin
      @(negedge clock);
      if (ic_rvalid || ic_done || busy) bad = 1;
    end
    mem_ack = 0;
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL midreset_late_ack: got activity=%b expected 0", bad);
    end
  endtask

  task automatic test_ignore();
    logic bad = 0;
    int k = 0;
    mem_rdata = 32'hBAD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      mem_ack = (c % 2 == 0);
      if (busy || mem_req || ic_rvalid || dc_rvalid) bad = 1;
    end
    @(negedge clock);
    mem_ack = 0;
    tests++;
    if (bad !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ack: activity=%b rdata=%h busy=%b expected 0/0/0", bad, rdata, busy);
    end
    ic_req = 1; ic_addr = 32'h5004; mem_ack = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (ic_done) ic_req = 0;
      if (mem_req) begin
        tests++;
        if (mem_addr !== 32'h5000 + 4 * k) begin
          fails++;
          $display("FAIL latched_addr: addr=%h expected %h", mem_addr, 32'h5000 + 4 * k);
        end
        k++;
        ic_addr = 32'h9FF0;
      end
    end
    mem_ack = 0;
    tests++;
    if (k !== 4) begin fails++; $display("FAIL latched_words: got %0d expected 4", k); end
  endtask

  task automatic test_rr_pending();
    logic ok;
    @(negedge clock);
    ic_req = 1; ic_addr = 32'h6000; mem_ack = 1;
    @(negedge clock);
    tests++;
    if (!mem_req || mem_addr !== 32'h6000) begin
      fails++;
      $display("FAIL rr_ic_first: req=%b addr=%h expected req=1 addr=00006000", mem_req, mem_addr);
    end
    dc_req = 1; dc_addr = 32'h7000; dc_we = 0;
    wait_done(1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rr_ic_done: got timeout expected ic_done"); end
    ic_req = 0;
    @(negedge clock);
    ic_req = 1;
    @(negedge clock);
    tests++;
    if (!mem_req || mem_addr !== 32'h7000 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL rr_dc_next: req=%b addr=%h we=%b expected 1/00007000/0", mem_req, mem_addr, mem_we);
    end
    wait_done(1'b1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rr_dc_done: got timeout expected dc_done"); end
    dc_req = 0;
    repeat (2) @(negedge clock);
    tests++;
    if (!mem_req || mem_addr !== 32'h6000) begin
      fails++;
      $display("FAIL rr_ic_follows: req=%b addr=%h expected req=1 addr=00006000", mem_req, mem_addr);
    end
    wait_done(1'b0, ok);
    ic_req = 0; mem_ack = 0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_tie();
    test_writeback();
    test_midreset();
    test_ignore();
    test_rr_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
